// File: rtl/jtoutrun_pkg.sv
// Shared definitions for the Out Run main/sub CPU bus bridge.
package jtoutrun_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [15:0] OPEN_BUS = 16'hFFFF;

endpackage

// File: rtl/jtoutrun_subbridge.sv
// Converts a main 68000 access to the sub-CPU window into a bus-request
// transaction on the sub bus, with a timeout so a hung sub CPU cannot lock the main bus.
module jtoutrun_subbridge
   import jtoutrun_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int TOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        win_cs,
   input  logic        main_ASn,
   input  logic [19:1] main_A,
   input  logic [1:0]  main_dsn,
   input  logic        main_rnw,
   input  logic [15:0] main_dout,
   output logic [15:0] main_din,
   output logic        main_ok,
   output logic        sub_br,
   output logic [19:1] br_A,
   output logic [1:0]  br_dsn,
   output logic        br_rnw,
   output logic [15:0] br_dout,
   input  logic [15:0] sub_din,
   input  logic        sub_ok,
   output logic        tout_err
);

   localparam int CW = $clog2(TOUT + 1);
   localparam int SETTLE_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
   localparam logic [CW-1:0] TOUT_C        = CW'(TOUT);
   localparam logic [CW-1:0] SETTLE_LAST_C = CW'(SETTLE_LAST_I);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sub_br_q, sub_br_d;
   logic          tout_err_q, tout_err_d;
   logic [15:0]   main_din_q, main_din_d;
   logic [19:1]   br_a_q, br_a_d;
   logic [1:0]    br_dsn_q, br_dsn_d;
   logic          br_rnw_q, br_rnw_d;
   logic [15:0]   br_dout_q, br_dout_d;
   logic          strobe;
   logic          drop_bus;

   assign strobe = win_cs & ~main_ASn & (main_dsn != 2'b11);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sub_br_d   = sub_br_q;
      tout_err_d = 1'b0;
      main_din_d = main_din_q;
      br_a_d     = br_a_q;
      br_dsn_d   = br_dsn_q;
      br_rnw_d   = br_rnw_q;
      br_dout_d  = br_dout_q;
      drop_bus   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (strobe) begin
               br_a_d    = main_A;
               br_dsn_d  = main_dsn;
               br_rnw_d  = main_rnw;
               br_dout_d = main_dout;
               sub_br_d  = 1'b1;
               cnt_d     = '0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            // Main CPU gave up the cycle: leave quietly, no ready and no error.
            if (main_ASn) begin
               drop_bus = 1'b1;
               state_d  = ST_IDLE;
            end else if (sub_ok) begin
               cnt_d   = '0;
               state_d = (SETTLE == 0) ? ST_WAIT : ST_SETTLE;
            end else if (cnt_q == TOUT_C) begin
               main_din_d = OPEN_BUS;
               tout_err_d = 1'b1;
               drop_bus   = 1'b1;
               state_d    = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SETTLE: begin
            if (main_ASn) begin
               drop_bus = 1'b1;
               state_d  = ST_IDLE;
            end else if (cnt_q == SETTLE_LAST_C) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT: begin
            if (main_ASn) begin
               drop_bus = 1'b1;
               state_d  = ST_IDLE;
            end else if (sub_ok) begin
               if (br_rnw_q) main_din_d = sub_din;
               drop_bus = 1'b1;
               state_d  = ST_DONE;
            end else if (cnt_q == TOUT_C) begin
               main_din_d = OPEN_BUS;
               tout_err_d = 1'b1;
               drop_bus   = 1'b1;
               state_d    = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (main_ASn) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Releasing the sub bus always returns the strobes/direction to idle.
      if (drop_bus) begin
         sub_br_d = 1'b0;
         br_dsn_d = 2'b11;
         br_rnw_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sub_br_q   <= 1'b0;
         tout_err_q <= 1'b0;
         main_din_q <= 16'h0000;
         br_a_q     <= '0;
         br_dsn_q   <= 2'b11;
         br_rnw_q   <= 1'b1;
         br_dout_q  <= 16'h0000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sub_br_q   <= sub_br_d;
         tout_err_q <= tout_err_d;
         main_din_q <= main_din_d;
         br_a_q     <= br_a_d;
         br_dsn_q   <= br_dsn_d;
         br_rnw_q   <= br_rnw_d;
         br_dout_q  <= br_dout_d;
      end
   end

   assign main_ok  = win_cs & (state_q == ST_DONE);
   assign main_din = main_din_q;
   assign sub_br   = sub_br_q;
   assign tout_err = tout_err_q;
   assign br_A     = br_a_q;
   assign br_dsn   = br_dsn_q;
   assign br_rnw   = br_rnw_q;
   assign br_dout  = br_dout_q;

endmodule

// File: tb/tb_jtoutrun_subbridge.sv
// Directed bench for jtoutrun_subbridge: reads, writes, settle glitch, timeout,
// main-side abort and asynchronous reset in the middle of a transfer.
module tb_jtoutrun_subbridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        win_cs;
   logic        main_ASn;
   logic [19:1] main_A;
   logic [1:0]  main_dsn;
   logic        main_rnw;
   logic [15:0] main_dout;
   logic [15:0] main_din;
   logic        main_ok;
   logic        sub_br;
   logic [19:1] br_A;
   logic [1:0]  br_dsn;
   logic        br_rnw;
   logic [15:0] br_dout;
   logic [15:0] sub_din;
   logic        sub_ok;
   logic        tout_err;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   jtoutrun_subbridge #(.SETTLE(2), .TOUT(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .win_cs   (win_cs),
      .main_ASn (main_ASn),
      .main_A   (main_A),
      .main_dsn (main_dsn),
      .main_rnw (main_rnw),
      .main_dout(main_dout),
      .main_din (main_din),
      .main_ok  (main_ok),
      .sub_br   (sub_br),
      .br_A     (br_A),
      .br_dsn   (br_dsn),
      .br_rnw   (br_rnw),
      .br_dout  (br_dout),
      .sub_din  (sub_din),
      .sub_ok   (sub_ok),
      .tout_err (tout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [19:1] a, input logic [1:0] dsn,
                        input logic rnw, input logic [15:0] dout);
      win_cs    = 1'b1;
      main_ASn  = 1'b0;
      main_A    = a;
      main_dsn  = dsn;
      main_rnw  = rnw;
      main_dout = dout;
   endtask

   task automatic end_cycle;
      main_ASn = 1'b1;
      win_cs   = 1'b0;
      main_dsn = 2'b11;
      sub_ok   = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; win_cs = 1'b1; main_ASn = 1'b1; main_A = '0; main_dsn = 2'b11;
      main_rnw = 1'b1; main_dout = '0; sub_din = '0; sub_ok = 1'b0;
      #2;
      chk_cnt++;
      if ({sub_br, main_ok, tout_err} !== 3'b000)
         $display("FAIL reset_ctrl: got %b want 000", {sub_br, main_ok, tout_err});
      else pass_cnt++;
      chk_cnt++;
      if (main_din !== 16'h0000) $display("FAIL reset_din: got %h want 0000", main_din);
      else pass_cnt++;
      chk_cnt++;
      if ({br_A, br_dsn, br_rnw, br_dout} !== {19'h0, 2'b11, 1'b1, 16'h0})
         $display("FAIL reset_br: got A=%h dsn=%b rnw=%b dout=%h", br_A, br_dsn, br_rnw, br_dout);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      win_cs = 1'b0;
      tick();
   endtask

   task automatic test_read;
      sub_ok = 1'b1; sub_din = 16'h1234;
      start(19'h30008, 2'b00, 1'b1, 16'h0000);   // byte address 0x60010
      tick();
      chk_cnt++;
      if ({sub_br, main_ok} !== 2'b10) $display("FAIL read_req: sub_br/main_ok got %b want 10", {sub_br, main_ok});
      else pass_cnt++;
      chk_cnt++;
      if (br_A !== 19'h30008) $display("FAIL read_addr: got %h want 30008", br_A);
      else pass_cnt++;
      for (int c = 2; c <= 4; c++) begin
         tick();
         chk_cnt++;
         if (main_ok !== 1'b0) $display("FAIL read_early_ok clk%0d: got %b want 0", c, main_ok);
         else pass_cnt++;
      end
      tick();
      chk_cnt++;
      if ({main_ok, tout_err, sub_br} !== 3'b100)
         $display("FAIL read_done: ok/err/br got %b want 100", {main_ok, tout_err, sub_br});
      else pass_cnt++;
      chk_cnt++;
      if (main_din !== 16'h1234) $display("FAIL read_data: got %h want 1234", main_din);
      else pass_cnt++;
      chk_cnt++;
      if (br_dsn !== 2'b11) $display("FAIL read_dsn_idle: got %b want 11", br_dsn);
      else pass_cnt++;
      // A second strobe while still in DONE must not start a new request.
      tick();
      chk_cnt++;
      if ({main_ok, sub_br} !== 2'b10) $display("FAIL read_hold: ok/br got %b want 10", {main_ok, sub_br});
      else pass_cnt++;
      win_cs = 1'b0;
      #1;
      chk_cnt++;
      if (main_ok !== 1'b0) $display("FAIL read_ok_gated: got %b want 0", main_ok);
      else pass_cnt++;
      win_cs = 1'b1;
      main_ASn = 1'b1;
      tick();
      chk_cnt++;
      if (main_ok !== 1'b0) $display("FAIL read_release: got %b want 0", main_ok);
      else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_write;
      bit done = 1'b0;
      sub_ok = 1'b0; sub_din = 16'hDEAD;
      start(19'h01234, 2'b10, 1'b0, 16'hABCD);
      tick();
      chk_cnt++;
      if ({sub_br, br_dsn, br_rnw, br_dout} !== {1'b1, 2'b10, 1'b0, 16'hABCD})
         $display("FAIL write_latch: br=%b dsn=%b rnw=%b dout=%h", sub_br, br_dsn, br_rnw, br_dout);
      else pass_cnt++;
      main_dout = 16'h0000; main_dsn = 2'b11; sub_ok = 1'b1;
      for (int i = 0; i < 12 && !done; i++) begin
         tick();
         if (main_ok) done = 1'b1;
         else begin
            chk_cnt++;
            if ({sub_br, br_dsn, br_rnw, br_dout} !== {1'b1, 2'b10, 1'b0, 16'hABCD})
               $display("FAIL write_hold: br=%b dsn=%b rnw=%b dout=%h", sub_br, br_dsn, br_rnw, br_dout);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (done !== 1'b1) $display("FAIL write_timeout: main_ok got 0 want 1 within 12 clocks");
      else pass_cnt++;
      chk_cnt++;
      if (main_din !== 16'h1234) $display("FAIL write_din_kept: got %h want 1234", main_din);
      else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_settle_glitch;
      sub_ok = 1'b1; sub_din = 16'h5555;
      start(19'h00001, 2'b00, 1'b1, 16'h0000);
      tick(); tick(); tick();          // REQ, SETTLE entered, glitch sampled in SETTLE
      sub_ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk_cnt++;
         if ({main_ok, sub_br} !== 2'b01) $display("FAIL glitch_wait %0d: ok/br got %b want 01", c, {main_ok, sub_br});
         else pass_cnt++;
      end
      sub_din = 16'h5A5A; sub_ok = 1'b1;
      tick();
      chk_cnt++;
      if ({main_ok, main_din} !== {1'b1, 16'h5A5A}) $display("FAIL glitch_done: ok=%b din=%h want 1/5a5a", main_ok, main_din);
      else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_timeout;
      sub_ok = 1'b0; sub_din = 16'h7777;
      start(19'h00002, 2'b00, 1'b1, 16'h0000);
      for (int c = 1; c <= 16; c++) begin
         tick();
         chk_cnt++;
         if ({tout_err, main_ok} !== 2'b00) $display("FAIL tout_early clk%0d: err/ok got %b want 00", c, {tout_err, main_ok});
         else pass_cnt++;
      end
      tick();
      chk_cnt++;
      if ({tout_err, main_ok, sub_br} !== 3'b110) $display("FAIL tout_abort: err/ok/br got %b want 110", {tout_err, main_ok, sub_br});
      else pass_cnt++;
      chk_cnt++;
      if (main_din !== 16'hFFFF) $display("FAIL tout_din: got %h want ffff", main_din);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({tout_err, main_ok} !== 2'b01) $display("FAIL tout_pulse: err/ok got %b want 01", {tout_err, main_ok});
      else pass_cnt++;
      main_ASn = 1'b1;
      tick();
      chk_cnt++;
      if (main_ok !== 1'b0) $display("FAIL tout_release: got %b want 0", main_ok);
      else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_asn_abort;
      sub_ok = 1'b1; sub_din = 16'h0BAD;
      start(19'h00003, 2'b00, 1'b1, 16'h0000);
      tick(); tick(); tick(); tick();  // now in WAIT
      main_ASn = 1'b1;                  // ASn rise together with sub_ok
      tick();
      chk_cnt++;
      if ({sub_br, main_ok, tout_err, br_dsn} !== 5'b00011)
         $display("FAIL asn_drop: br/ok/err/dsn got %b want 00011", {sub_br, main_ok, tout_err, br_dsn});
      else pass_cnt++;
      chk_cnt++;
      if (main_din !== 16'hFFFF) $display("FAIL asn_discard: got %h want ffff", main_din);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({main_ok, sub_br} !== 2'b00) $display("FAIL asn_idle: ok/br got %b want 00", {main_ok, sub_br});
      else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_reset_mid;
      sub_ok = 1'b1; sub_din = 16'h1111;
      start(19'h00004, 2'b00, 1'b1, 16'h0000);
      tick(); tick();
      sub_ok = 1'b0;
      tick(); tick(); tick();          // waiting in WAIT
      rst = 1'b1;
      #1;
      chk_cnt++;
      if ({sub_br, main_ok, br_dsn, main_din, br_A} !== {1'b0, 1'b0, 2'b11, 16'h0000, 19'h0})
         $display("FAIL rst_mid: br=%b ok=%b dsn=%b din=%h A=%h", sub_br, main_ok, br_dsn, main_din, br_A);
      else pass_cnt++;
      main_ASn = 1'b1; win_cs = 1'b0; main_dsn = 2'b11;
      @(negedge clk);
      rst = 1'b0;
      tick();
      sub_ok = 1'b1; sub_din = 16'h2468;
      start(19'h00005, 2'b01, 1'b1, 16'h0000);
      tick();
      chk_cnt++;
      if (sub_br !== 1'b1) $display("FAIL rst_new_req: sub_br got %b want 1", sub_br);
      else pass_cnt++;
      tick(); tick(); tick();
      chk_cnt++;
      if (main_ok !== 1'b0) $display("FAIL rst_new_early: main_ok got %b want 0", main_ok);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({main_ok, main_din} !== {1'b1, 16'h2468}) $display("FAIL rst_new_done: ok=%b din=%h want 1/2468", main_ok, main_din);
      else pass_cnt++;
      end_cycle();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_settle_glitch();
      test_timeout();
      test_asn_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
